uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Downstream of the response frame builder's TX FIFO. The block pops bytes from a first-word-fall-through FIFO and serializes each one onto the UART line as 8N1 (or 8N2), LSB first. Bytes are sent back-to-back with no idle gap while the FIFO holds data, so a response frame (SOF, STATUS, CMD, [ADDR, DATA], CRC) leaves the device contiguously.

Parameters:
CLK_FREQ_HZ, 125000000, system clock frequency.
BAUD_RATE, 115200, line rate.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
fifo_rd_data  in  8  FWFT FIFO head byte; valid when fifo_empty=0.
fifo_empty  in  1  FIFO has no data.
fifo_rd_en  out  1  single-cycle pop strobe.
uart_tx  out  1  serial line, idle high.
tx_busy  out  1  high while a byte is on the line.
tx_byte_done  out  1  one-cycle pulse at the end of each stop period.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: uart_tx=1, tx_busy=0, tx_byte_done=0, fifo_rd_en=0 (forced low while rst), state=IDLE, counters=0.
- Bit period: BAUD_DIV = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE, rounded. Elaboration $error if BAUD_DIV < 2 or STOP_BITS is not 1 or 2.
- Baud counter: width $clog2(BAUD_DIV), counts 0..BAUD_DIV-1. bit_tick fires when count == BAUD_DIV-1. The counter restarts at 0 on every byte start.
- FSM states and transitions:
  - IDLE:
    - If fifo_empty=0, assert fifo_rd_en combinationally this cycle.
    - Latch fifo_rd_data into shift_reg and go to START.
  - START:
    - uart_tx=0 for BAUD_DIV cycles.
    - On bit_tick, go to DATA with bit_idx=0.
  - DATA:
    - uart_tx=shift_reg[bit_idx], 8 bits, LSB first.
    - On each bit_tick, increment bit_idx.
    - After bit 7, go to STOP.
  - STOP:
    - uart_tx=1 for STOP_BITS*BAUD_DIV cycles.
    - On the final tick, pulse tx_byte_done.
    - If fifo_empty=0 in that same cycle, assert fifo_rd_en, latch the next byte and go directly to START (zero-gap back-to-back). Otherwise go to IDLE.
- Outputs are registered: uart_tx, tx_busy and tx_byte_done. uart_tx goes low on the clock edge after the cycle in which fifo_rd_en is asserted.
- Byte duration: (9 + STOP_BITS) * BAUD_DIV cycles. fifo_rd_en asserts at most once per byte.
- tx_busy is 1 in START, DATA and STOP; 0 in IDLE.
- fifo_empty toggling mid-byte has no effect, because the byte is already latched.
- Reset mid-byte:
  - uart_tx returns high on the next edge and the byte is abandoned.
  - No pop occurs during rst.

Optional Feature:
UART_TX_CTS_EN
- Defined:
  - Adds input port cts_n (1 bit, active-low clear-to-send).
  - cts_n passes through a 2-flop synchronizer.
  - A new byte is popped and started (from IDLE or from the end of STOP) only when the synchronized cts_n is 0.
  - A byte already in progress always completes.
- Undefined: the port is absent and the block behaves as if clear-to-send is always asserted.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - localparam UART_DATA_BITS = 8.
  - Function calc_baud_div(clk_hz, baud) returning the rounded divider.
- Sub-module uart_baud_gen:
  - Parameter BAUD_DIV.
  - Inputs: clk, rst, restart.
  - Output: bit_tick.
  - Counter behaviour as specified above.

Test Plan:
(CLK_FREQ_HZ=1000000, BAUD_RATE=100000, so BAUD_DIV=10, unless noted.)
1. Single byte 0x5A with STOP_BITS=1
   - One fifo_rd_en pulse.
   - Line low for 10 cycles, then bits 0,1,0,1,1,0,1,0 at 10 cycles each, then high for 10.
   - tx_byte_done pulses 100 cycles after the pop; tx_busy then falls.
2. FIFO preloaded with 0x5A, 0x00, 0x20, 0xC3
   - Exactly 4 pops.
   - Contiguous 400-cycle waveform with no idle cycles between stop and the next start bit.
   - 4 tx_byte_done pulses, spaced 100 cycles apart.
3. rst asserted during DATA bit 3 of 0xA5
   - uart_tx=1 and tx_busy=0 on the next edge; no pop during reset.
   - Next byte 0x3C after reset transmits complete and correct.
4. fifo_empty held at 1 for 1000 cycles
   - uart_tx stays 1.
   - fifo_rd_en, tx_busy and tx_byte_done never assert.
5. STOP_BITS=2, byte 0xFF
   - Start bit low for 10 cycles, data high for 80, stop high for 20.
   - tx_byte_done 110 cycles after the pop.
6. UART_TX_CTS_EN defined
   - cts_n=1 with data waiting: no pop for 500 cycles.
   - Drop cts_n: pop within 3 cycles.
   - Raise cts_n mid-byte: current byte completes and the next is not started.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Divider rounded to the nearest whole clock count.
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clock of each bit period,
// and restart realigns the period to the start of a new byte.
module uart_baud_gen #(
  parameter int BAUD_DIV = 1085
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  assign bit_tick = (count_reg == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst || restart || bit_tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter draining a FWFT FIFO back-to-back, LSB first.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUD_RATE   = 115200,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_rd_data,
  input  logic       fifo_empty,
`ifdef UART_TX_CTS_EN
  input  logic       cts_n,
`endif
  output logic       fifo_rd_en,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_byte_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_serializer: BAUD_DIV must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_t                 state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]                bit_idx_reg, bit_idx_next;
  logic                      stop_cnt_reg, stop_cnt_next;
  logic                      uart_tx_reg, uart_tx_next;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;
  logic                      bit_tick;
  logic                      restart;
  logic                      clear_to_send;
  logic                      pop_ok;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_reg;

  // Reset to "not clear" so nothing leaves before the peer is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_sync_reg <= 2'b11;
    end else begin
      cts_sync_reg <= {cts_sync_reg[0], cts_n};
    end
  end

  assign clear_to_send = ~cts_sync_reg[1];
`else
  assign clear_to_send = 1'b1;
`endif

  assign pop_ok = ~fifo_empty & clear_to_send & ~rst;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_cnt_next = stop_cnt_reg;
    fifo_rd_en    = 1'b0;
    restart       = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pop_ok) begin
          fifo_rd_en = 1'b1;
          restart    = 1'b1;
          shift_next = fifo_rd_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_reg == LAST_BIT) begin
            state_next    = STOP;
            stop_cnt_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            done_next = 1'b1;
            // Chain straight into the next start bit when data is waiting.
            if (pop_ok) begin
              fifo_rd_en = 1'b1;
              restart    = 1'b1;
              shift_next = fifo_rd_data;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered so the output stays registered.
    uart_tx_next = 1'b1;
    case (state_next)
      START:   uart_tx_next = 1'b0;
      DATA:    uart_tx_next = shift_next[bit_idx_next];
      default: uart_tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      uart_tx_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_cnt_reg <= stop_cnt_next;
      uart_tx_reg  <= uart_tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign uart_tx      = uart_tx_reg;
  assign tx_busy      = busy_reg;
  assign tx_byte_done = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: instance 0 uses one stop bit, instance 1 uses two.
module tb_uart_tx_serializer;

  localparam int BD = 10;

  typedef struct packed {
    logic [7:0] data;
    logic       b2b;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] rd_v, tx_v, busy_v, done_v, empty_v;
  logic [7:0] data_v [2];
  logic [7:0] mem [2][16];
  logic [3:0] rd_ptr [2];
  logic [3:0] wr_ptr [2];
  int         pops [2];
  int         empty_pop_err;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   in_byte [2];
  bit   done_due [2];
  bit   have_end [2];
  int   k [2];
  int   end_cyc [2];
  int   last_pops [2];
  int   wave_err [2];
  int   busy_err [2];
  logic [7:0] rx [2];
  exp_t cur [2];
  int   spurious_done = 0;
  int   extra_pop = 0;
  int   idle_busy_err = 0;
  int   rst_pop_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign empty_v[gi] = (rd_ptr[gi] == wr_ptr[gi]);
    assign data_v[gi]  = mem[gi][rd_ptr[gi]];

    uart_tx_serializer #(
      .CLK_FREQ_HZ(1000000),
      .BAUD_RATE  (100000),
      .STOP_BITS  (gi + 1)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_rd_data(data_v[gi]),
      .fifo_empty  (empty_v[gi]),
`ifdef UART_TX_CTS_EN
      .cts_n       (cts_n),
`endif
      .fifo_rd_en  (rd_v[gi]),
      .uart_tx     (tx_v[gi]),
      .tx_busy     (busy_v[gi]),
      .tx_byte_done(done_v[gi])
    );
  end

  // FWFT FIFO model feeding each instance.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rd_ptr[i] = '0;
      wr_ptr[i] = '0;
      pops[i]   = 0;
    end
    empty_pop_err = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_v[i]) begin
        if (rd_ptr[i] == wr_ptr[i]) empty_pop_err <= empty_pop_err + 1;
        else rd_ptr[i] <= rd_ptr[i] + 4'd1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  function automatic string nm(input string s, input int i);
    return $sformatf("%s_dut%0d", s, i);
  endfunction

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sb_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t sb_pop(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic push(input int i, input logic [7:0] d, input logic b2b);
    exp_t e;
    e.data = d;
    e.b2b  = b2b;
    mem[i][wr_ptr[i]] = d;
    wr_ptr[i] = wr_ptr[i] + 4'd1;
    if (i == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    $display("push dut%0d byte=0x%02h b2b=%0b", i, d, b2b);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int i, input int budget);
    int n = 0;
    while ((sb_size(i) != 0 || in_byte[i] || done_due[i]) && n < budget) begin
      tick();
      n++;
    end
    check_eq(nm("drain_in_time", i), longint'(n < budget), 1);
  endtask

  // Monitor: rebuilds each byte from the line and compares against the scoreboard.
  initial begin : monitor
    int   bl;
    int   delta;
    logic exp_bit;
    for (int i = 0; i < 2; i++) begin
      in_byte[i] = 0; done_due[i] = 0; have_end[i] = 0; last_pops[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bl = (10 + i) * BD;
        delta = pops[i] - last_pops[i];
        last_pops[i] = pops[i];
        if (rst) begin
          rst_pop_err += delta;
          in_byte[i] = 0; done_due[i] = 0; have_end[i] = 0;
          continue;
        end
        if (done_due[i]) begin
          check_eq(nm("byte_done_pulse", i), longint'(done_v[i]), 1);
          done_due[i] = 0;
        end else if (done_v[i]) begin
          spurious_done++;
        end
        if (!in_byte[i] && !tx_v[i]) begin
          check_eq(nm("start_expected", i), longint'(sb_size(i) > 0), 1);
          if (sb_size(i) > 0) cur[i] = sb_pop(i);
          else cur[i] = '0;
          check_eq(nm("pop_before_start", i), delta, 1);
          if (cur[i].b2b && have_end[i])
            check_eq(nm("stop_to_start_gap", i), cyc - end_cyc[i] - 1, 0);
          in_byte[i] = 1; k[i] = 0; wave_err[i] = 0; busy_err[i] = 0; rx[i] = '0;
        end else begin
          extra_pop += delta;
        end
        if (in_byte[i]) begin
          if (k[i] < BD) exp_bit = 1'b0;
          else if (k[i] < 9 * BD) exp_bit = cur[i].data[k[i] / BD - 1];
          else exp_bit = 1'b1;
          if (tx_v[i] != exp_bit) wave_err[i]++;
          if (k[i] >= BD && k[i] < 9 * BD && (k[i] % BD) == BD / 2)
            rx[i][k[i] / BD - 1] = tx_v[i];
          if (!busy_v[i]) busy_err[i]++;
          if (k[i] == bl - 1) begin
            $display("rx dut%0d byte=0x%02h expected=0x%02h wave_err=%0d", i, rx[i], cur[i].data, wave_err[i]);
            check_eq(nm("rx_data", i), longint'(rx[i]), longint'(cur[i].data));
            check_eq(nm("waveform_errors", i), wave_err[i], 0);
            check_eq(nm("busy_low_in_byte", i), busy_err[i], 0);
            in_byte[i] = 0; done_due[i] = 1; have_end[i] = 1; end_cyc[i] = cyc;
          end
          k[i]++;
        end else if (busy_v[i]) begin
          idle_busy_err++;
        end
      end
    end
  end

  initial begin : stimulus
    int p;
    int n;
    int viol;
    rst = 1'b1;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) mem[i][j] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check_eq(nm("reset_uart_tx", i), longint'(tx_v[i]), 1);
      check_eq(nm("reset_busy", i), longint'(busy_v[i]), 0);
      check_eq(nm("reset_done", i), longint'(done_v[i]), 0);
      check_eq(nm("reset_rd_en", i), longint'(rd_v[i]), 0);
    end
    rst = 1'b0;
    repeat (5) tick();

    // Empty FIFO: the line must stay quiet.
    viol = 0;
    p = pops[0] + pops[1];
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (tx_v != 2'b11 || rd_v != 2'b00 || busy_v != 2'b00 || done_v != 2'b00) viol++;
    end
    check_eq("idle_quiet", viol, 0);
    check_eq("idle_no_pops", pops[0] + pops[1] - p, 0);

    // Single byte.
    p = pops[0];
    push(0, 8'h5A, 1'b0);
    wait_drain(0, 300);
    check_eq("single_pop_count", pops[0] - p, 1);
    repeat (5) tick();

    // Preloaded frame must leave contiguously.
    p = pops[0];
    push(0, 8'h5A, 1'b0);
    push(0, 8'h00, 1'b1);
    push(0, 8'h20, 1'b1);
    push(0, 8'hC3, 1'b1);
    wait_drain(0, 700);
    check_eq("frame_pop_count", pops[0] - p, 4);
    repeat (5) tick();

    // Reset in the middle of bit 3.
    p = pops[0];
    push(0, 8'hA5, 1'b0);
    n = 0;
    while (pops[0] == p && n < 20) begin
      tick();
      n++;
    end
    check_eq("a5_popped", longint'(pops[0] - p), 1);
    repeat (45) tick();
    rst = 1'b1;
    tick();
    check_eq("midbyte_rst_uart_tx", longint'(tx_v[0]), 1);
    check_eq("midbyte_rst_busy", longint'(busy_v[0]), 0);
    p = pops[0];
    push(0, 8'h3C, 1'b0);
    repeat (3) tick();
    check_eq("no_pop_in_reset", pops[0] - p, 0);
    rst = 1'b0;
    wait_drain(0, 300);
    check_eq("after_reset_pop_count", pops[0] - p, 1);

    // Two stop bits.
    p = pops[1];
    push(1, 8'hFF, 1'b0);
    wait_drain(1, 300);
    check_eq("stop2_pop_count", pops[1] - p, 1);

`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    repeat (5) tick();
    p = pops[0];
    push(0, 8'h11, 1'b0);
    repeat (500) tick();
    check_eq("cts_hold_no_pop", pops[0] - p, 0);
    cts_n = 1'b0;
    n = 0;
    while (!rd_v[0] && n < 10) begin
      tick();
      n++;
    end
    check_eq("cts_pop_within_3", longint'(n <= 3), 1);
    repeat (30) tick();
    cts_n = 1'b1;
    push(0, 8'h22, 1'b0);
    n = 0;
    while ((in_byte[0] || done_due[0]) && n < 200) begin
      tick();
      n++;
    end
    check_eq("cts_byte_completes", longint'(n < 200), 1);
    p = pops[0];
    repeat (300) tick();
    check_eq("cts_next_not_started", pops[0] - p, 0);
    check_eq("cts_pending_bytes", sb_size(0), 1);
    cts_n = 1'b0;
    wait_drain(0, 300);
`endif

    repeat (10) tick();
    check_eq("spurious_done", spurious_done, 0);
    check_eq("extra_pops", extra_pop, 0);
    check_eq("busy_while_idle", idle_busy_err, 0);
    check_eq("pops_in_reset", rst_pop_err, 0);
    check_eq("pop_from_empty", empty_pop_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
